shared_bus_arbiter: RTL and testbench
=====================================

SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of consecutive granted cycles per tenure (legal 2..255).
REQ-002 SHALL have parameter DATA_W, default 64, meaning the shared bus width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 reqA1  input  1  bus request, requester A1.
REQ-006 reqA2  input  1  bus request, requester A2.
REQ-007 dataA1  input  DATA_W  write data, requester A1.
REQ-008 dataA2  input  DATA_W  write data, requester A2.
REQ-009 gntA1  output  1  grant, requester A1 (registered).
REQ-010 gntA2  output  1  grant, requester A2 (registered).
REQ-011 sharedBusTop  output  DATA_W  registered shared bus.
REQ-012 busValid  output  1  sharedBusTop carries owner data this cycle.
REQ-013 timeoutErr  output  1  one-cycle pulse on forced release.

Function
REQ-014 SHALL implement FSM states IDLE, GNT_A1, GNT_A2, RELEASE; gntA1=1 only in GNT_A1, gntA2=1 only in GNT_A2; gntA1 and gntA2 SHALL never both be 1.
REQ-015 IDLE: an eligible request sampled at edge k SHALL move to the matching GNT state, so the grant is visible after edge k (one-cycle latency).
REQ-016 Both eligible requests at the same edge SHALL be resolved by the round-robin pointer prio; prio SHALL flip to the non-served requester on every exit from a GNT state.
REQ-017 Eligibility: a requester SHALL be ineligible after its tenure ends until its req is observed low for at least one edge (four-phase handshake).
REQ-018 GNT_x: each edge SHALL load sharedBusTop <= dataX and set busValid=1; the hold counter SHALL increment from 0.
REQ-019 GNT_x with reqX low at an edge SHALL transition to RELEASE, without timeoutErr.
REQ-020 GNT_x with reqX high and hold counter equal to MAX_HOLD-1 SHALL transition to RELEASE and pulse timeoutErr for exactly one cycle.
REQ-021 reqX falling at the same edge as the counter limit SHALL count as a normal release (timeoutErr=0).
REQ-022 RELEASE SHALL last exactly one cycle, with both grants 0, busValid=0, and sharedBusTop holding its last value; the next state SHALL be chosen as from IDLE.
REQ-023 The hold counter SHALL be $clog2(MAX_HOLD+1) bits wide, SHALL clear on entry to a GNT state, and SHALL never wrap.

Reset
REQ-024 rst low SHALL immediately force: state IDLE, gntA1=0, gntA2=0, sharedBusTop=0, busValid=0, timeoutErr=0, prio=A1, counter=0, both requesters eligible.
REQ-025 Reset asserted mid-tenure SHALL drop the grant asynchronously; after release, the first grant SHALL follow REQ-015 from the next edge.

Structure
REQ-026 SHALL place the state enum (arb_state_t) and the requester-ID typedef in a shared package, arb_pkg.
REQ-027 SHALL have one sub-module, rr_pick, which is combinational: eligible requests plus prio in, winner out.
REQ-028 SHALL have a datapath mux and output registers inside shared_bus_arbiter; the block SHALL replace the combinational controller in top.

Verification
REQ-029 Single request: reqA1=1 with dataA1=64'hA5A5_0000_0000_0001 -> gntA1=1 after the next edge, busValid=1, sharedBusTop=64'hA5A5_0000_0000_0001; reqA1=0 -> one RELEASE cycle, then IDLE.
REQ-030 Simultaneous: reqA1=reqA2=1 from reset -> A1 granted first, then RELEASE, then A2 granted; grants never overlap.
REQ-031 Timeout: MAX_HOLD=4, reqA2 held high -> gntA2 high for 4 cycles, timeoutErr pulses once, and A2 is not re-granted until reqA2 has gone low.
REQ-032 Timeout collision: reqA1 drops at the edge the counter reaches 3 (MAX_HOLD=4) -> timeoutErr stays 0.
REQ-033 Reset mid-grant: rst low during GNT_A2 -> gntA2=0 and sharedBusTop=0 without waiting for a clock edge; after release, reqA2 is granted one edge later.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared types for the two-requester shared-bus arbiter: FSM state
//            encoding, requester identifiers and a small helper function.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Arbiter controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_A1  = 2'd1,
    GNT_A2  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Requester identifier; also used as the round-robin priority pointer
  typedef enum logic {
    REQ_A1 = 1'b0,
    REQ_A2 = 1'b1
  } req_id_t;

  // The requester that is not 'id'
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A1) ? REQ_A2 : REQ_A1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational two-way round-robin pick. A lone eligible request
//            wins outright; two eligible requests are resolved by prio_i.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import arb_pkg::*;
(
  input  logic    [1:0] elig_req_i,   // bit0 = A1, bit1 = A2
  input  req_id_t       prio_i,
  output logic          win_valid_o,
  output req_id_t       win_o
);

  // Winner selection: single requester wins, contention goes to the pointer
  always_comb begin
    win_valid_o = |elig_req_i;
    win_o       = prio_i;
    if (elig_req_i == 2'b01) begin
      win_o = REQ_A1;
    end else if (elig_req_i == 2'b10) begin
      win_o = REQ_A2;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_bus_arbiter
// Purpose  : Grants a shared registered data bus to one of two requesters
//            with round-robin fairness, a bounded tenure (MAX_HOLD cycles)
//            and a four-phase re-request rule after a forced release.
// Revision : 1.0 - initial release
// ============================================================================
module shared_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              reqA1,
  input  logic              reqA2,
  input  logic [DATA_W-1:0] dataA1,
  input  logic [DATA_W-1:0] dataA2,
  output logic              gntA1,
  output logic              gntA2,
  output logic [DATA_W-1:0] sharedBusTop,
  output logic              busValid,
  output logic              timeoutErr
);

  localparam int unsigned      CNT_W      = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  req_id_t           prio_q,  prio_d;
  logic [1:0]        elig_q,  elig_d;
  logic              gnt_a1_q, gnt_a1_d;
  logic              gnt_a2_q, gnt_a2_d;
  logic [DATA_W-1:0] bus_q,   bus_d;
  logic              valid_q, valid_d;
  logic              terr_q,  terr_d;

  logic [1:0]        elig_req;
  logic              win_valid;
  req_id_t           win;
  req_id_t           owner;
  logic              owner_req;

  assign elig_req = {reqA2 & elig_q[1], reqA1 & elig_q[0]};

  rr_pick u_rr_pick (
    .elig_req_i  (elig_req),
    .prio_i      (prio_q),
    .win_valid_o (win_valid),
    .win_o       (win)
  );

  // Controller: next state, tenure counter, priority pointer, eligibility
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    elig_d    = elig_q;
    terr_d    = 1'b0;
    owner     = (state_q == GNT_A2) ? REQ_A2 : REQ_A1;
    owner_req = (state_q == GNT_A2) ? reqA2 : reqA1;

    // Seeing a request low at any edge completes the handshake
    if (!reqA1) elig_d[0] = 1'b1;
    if (!reqA2) elig_d[1] = 1'b1;

    unique case (state_q)
      IDLE, RELEASE: begin
        state_d = IDLE;
        if (win_valid) begin
          state_d = (win == REQ_A1) ? GNT_A1 : GNT_A2;
          cnt_d   = '0;
        end
      end
      GNT_A1, GNT_A2: begin
        if (!owner_req) begin
          // Voluntary release takes precedence over the hold limit
          state_d = RELEASE;
          prio_d  = other_req(owner);
        end else if (cnt_q == HOLD_LIMIT) begin
          // Forced release: owner must drop its request before re-arbitrating
          state_d       = RELEASE;
          prio_d        = other_req(owner);
          terr_d        = 1'b1;
          elig_d[owner] = 1'b0;
        end else if (cnt_q < HOLD_LIMIT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: registered outputs follow the state being entered
  always_comb begin
    gnt_a1_d = (state_d == GNT_A1);
    gnt_a2_d = (state_d == GNT_A2);
    valid_d  = gnt_a1_d | gnt_a2_d;
    bus_d    = bus_q;
    if (gnt_a1_d) begin
      bus_d = dataA1;
    end else if (gnt_a2_d) begin
      bus_d = dataA2;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prio_q   <= REQ_A1;
      elig_q   <= 2'b11;
      gnt_a1_q <= 1'b0;
      gnt_a2_q <= 1'b0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      elig_q   <= elig_d;
      gnt_a1_q <= gnt_a1_d;
      gnt_a2_q <= gnt_a2_d;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
    end
  end

  assign gntA1        = gnt_a1_q;
  assign gntA2        = gnt_a2_q;
  assign sharedBusTop = bus_q;
  assign busValid     = valid_q;
  assign timeoutErr   = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_bus_arbiter
// Purpose  : Self-checking bench for shared_bus_arbiter (MAX_HOLD = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_bus_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int DATA_W   = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req1, req2;
  logic [DATA_W-1:0] d1, d2;
  logic              gntA1, gntA2, busValid, timeoutErr;
  logic [DATA_W-1:0] sharedBusTop;

  shared_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .reqA1        (req1),
    .reqA2        (req2),
    .dataA1       (d1),
    .dataA2       (d2),
    .gntA1        (gntA1),
    .gntA2        (gntA2),
    .sharedBusTop (sharedBusTop),
    .busValid     (busValid),
    .timeoutErr   (timeoutErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              g1;
    logic              g2;
    logic              v;
    logic              t;
    logic [DATA_W-1:0] bus;
  } exp_t;

  typedef struct packed {
    logic              own;
    logic [DATA_W-1:0] data;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    run      = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 none), cycles granted so far, must-drop flags
  int                m_owner = -1;
  int                m_held  = 0;
  bit                m_drop[2];
  int                m_rr    = 0;
  logic [DATA_W-1:0] m_bus   = '0;

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_drop[0] = 1'b0;
    m_drop[1] = 1'b0;
    m_rr      = 0;
    m_bus     = '0;
  endtask

  task automatic push_outputs(input bit terr);
    exp_t  e;
    beat_t b;
    e.g1  = (m_owner == 0);
    e.g2  = (m_owner == 1);
    e.v   = (m_owner >= 0);
    e.t   = terr;
    e.bus = m_bus;
    exp_q.push_back(e);
    if (m_owner >= 0) begin
      b.own  = (m_owner == 1);
      b.data = m_bus;
      beat_q.push_back(b);
    end
  endtask

  // Advance the model by one clock edge using the inputs the bench drove
  task automatic model_step();
    bit                r[2];
    bit                c[2];
    logic [DATA_W-1:0] d[2];
    bit                terr;
    int                w;
    terr = 1'b0;
    if (!rst_n) begin
      model_reset();
      push_outputs(1'b0);
      return;
    end
    r[0] = req1; r[1] = req2;
    d[0] = d1;   d[1] = d2;
    for (int i = 0; i < 2; i++) if (!r[i]) m_drop[i] = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_rr    = 1 - m_owner;
        m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
        terr            = 1'b1;
        m_drop[m_owner] = 1'b1;
        m_rr            = 1 - m_owner;
        m_owner         = -1;
      end else begin
        m_held++;
        m_bus = d[m_owner];
      end
    end else begin
      c[0] = r[0] && !m_drop[0];
      c[1] = r[1] && !m_drop[1];
      if (c[0] && c[1]) w = m_rr;
      else if (c[0])    w = 0;
      else if (c[1])    w = 1;
      else              w = -1;
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
        m_bus   = d[w];
      end
    end
    push_outputs(terr);
  endtask

  // One clock: model the edge just taken, then drive inputs for the next edge
  task automatic tick_d(input bit r1, input bit r2,
                        input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    @(posedge clk);
    #1;
    model_step();
    req1 = r1;
    req2 = r2;
    d1   = v1;
    d2   = v2;
  endtask

  task automatic tick(input bit r1, input bit r2);
    tick_d(r1, r2, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Assert reset between edges; outputs must clear without a clock edge
  task automatic apply_reset(input bit r1, input bit r2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_gntA1", gntA1, 0);
    chk("rst_async_gntA2", gntA2, 0);
    chk("rst_async_bus", sharedBusTop, 0);
    chk("rst_async_busValid", busValid, 0);
    chk("rst_async_timeoutErr", timeoutErr, 0);
    model_reset();
    push_outputs(1'b0);
    req1 = r1;
    req2 = r2;
    tick(r1, r2);
    tick(r1, r2);
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle control/bus check, plus a beat check on busValid
  always begin
    exp_t  e;
    beat_t b;
    @(negedge clk);
    if (run) begin
      if (exp_q.size() == 0) begin
        chk("exp_queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("gntA1", gntA1, e.g1);
        chk("gntA2", gntA2, e.g2);
        chk("busValid", busValid, e.v);
        chk("timeoutErr", timeoutErr, e.t);
        chk("sharedBusTop", sharedBusTop, e.bus);
      end
      chk("grant_overlap", gntA1 & gntA2, 0);
      if (busValid) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          b = beat_q.pop_front();
          chk("beat_owner", gntA2, b.own);
          chk("beat_data", sharedBusTop, b.data);
        end
      end
    end
  end

  initial begin
    bit r1, r2;
    rst_n = 1'b0;
    req1  = 1'b0;
    req2  = 1'b0;
    d1    = '0;
    d2    = '0;
    run   = 1'b1;

    // Reset state, then release
    tick(0, 0);
    tick(0, 0);
    rst_n = 1'b1;
    tick(0, 0);

    // Single request with a known data word, then voluntary release
    tick_d(1, 0, 64'hA5A5_0000_0000_0001, 64'h0);
    tick_d(1, 0, 64'hA5A5_0000_0000_0001, 64'h0);
    tick(0, 0);
    tick(0, 0);
    tick(0, 0);

    // Simultaneous requests from reset: A1 first, both time out
    apply_reset(0, 0);
    for (int i = 0; i < 14; i++) tick(1, 1);
    tick(0, 0);
    tick(0, 0);

    // Timeout on A2 held high; no re-grant until it drops
    for (int i = 0; i < 10; i++) tick(0, 1);
    tick(0, 0);
    tick(0, 1);
    tick(0, 0);
    tick(0, 0);

    // A1 drops on the same edge the hold limit would fire
    for (int i = 0; i < 4; i++) tick(1, 0);
    tick(0, 0);
    tick(0, 0);

    // Reset mid-grant on A2, then A2 granted one edge after release
    tick(0, 1);
    tick(0, 1);
    tick(0, 1);
    apply_reset(0, 1);
    tick(0, 1);
    tick(0, 0);
    tick(0, 0);

    // Randomized traffic with sticky requests and occasional reset
    for (int n = 0; n < 800; n++) begin
      r1 = req1 ? ($urandom_range(7, 0) != 0) : ($urandom_range(2, 0) == 0);
      r2 = req2 ? ($urandom_range(7, 0) != 0) : ($urandom_range(2, 0) == 0);
      if ($urandom_range(199, 0) == 0) apply_reset(r1, r2);
      else tick(r1, r2);
    end
    tick(0, 0);
    tick(0, 0);

    @(negedge clk);
    #1;
    chk("exp_queue_drained", 64'(exp_q.size()), 0);
    chk("beat_queue_drained", 64'(beat_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
